fft_peak_search: RTL and testbench
==================================

# fft_peak_search

Parametrised streaming peak finder for FFT output frames in the phase-2 frequency-tracking chain. It accepts one complex bin per clock while `opd_o` is high. Over a programmable bin window it finds the bin with the largest |X|², and reports that bin's index, its signed real/imag values, its magnitude and both neighbouring-bin magnitudes to the CORDIC/interpolation stage. Each frame produces exactly one result at a fixed latency; results hold until the next frame.

## Interface
- `DW`, 28: signed width of `fft_real`/`fft_imag` (two's complement).
- `IW`, 10: bin index width.
- `MW`, 2*DW: magnitude-squared width (derived; do not override).

- `clk`  in  1  sample clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `opd_o`  in  1  FFT output-valid; high for one contiguous run per frame.
- `idx_o`  in  IW  bin index; increments by 1 on every valid sample.
- `fft_real`  in  DW  bin real part, signed.
- `fft_imag`  in  DW  bin imag part, signed.
- `lo_bin`, `hi_bin`  in  IW each  inclusive search window; sampled on the first valid sample of a frame.
- `min_mag`  in  MW  detection threshold; sampled on the first valid sample of a frame.
- `result_valid`  out  1  one-cycle pulse per completed frame.
- `peak_found`  out  1  1 if the winning magnitude is >= `min_mag` and at least one in-window bin was seen.
- `max_idx_result`  out  IW  winning bin index.
- `max_re_result`, `max_im_result`  out  DW each  winning bin values, unmodified, sign included.
- `max_mag_result`  out  MW  re²+im² of the winning bin.
- `left_mag_result`, `right_mag_result`  out  MW each  |X|² of the stream samples immediately before and after the winning sample.

## Operation
- Arming: after reset the block is DISARMED. It arms on the first cycle with `opd_o`=0, so a partial frame in flight at reset release is ignored entirely (no result).
- Frame start: the first valid sample when armed. It carries a `first` tag down the pipe; at the compare stage the tag clears the best record and the "left" shadow.
- Frame end: the last sample before `opd_o` falls. It carries a `last` tag; the result is emitted when the tag reaches the output stage.
- Pipeline, one sample per cycle, no stalls: S1 registers inputs and tags. S2 squares re and im (signed×signed, unsigned 2DW-1-bit products). S3 computes mag = re²+im² (MW bits, no overflow possible). S4 runs compare/update. S5 loads the outputs.
- Compare: only samples with `lo_bin` <= idx <= `hi_bin` are candidates. A candidate updates best only if mag > best_mag, so on ties the first (lowest index) bin wins. The first in-window candidate always loads.
- Neighbours:
  - On update, `left_mag` is set to the previous stream sample's mag, even if that sample is out of window. It is 0 if the candidate is the frame's first sample.
  - `right_mag` is set to the next stream sample's mag on the following cycle. It is 0 if the winner is the frame's last sample.
- Empty window (no candidates, or `lo_bin` > `hi_bin`): the result still pulses, with `peak_found`=0 and all data outputs 0.
- Back-to-back frames: `opd_o` may be low for as little as one cycle between frames. Tags keep the frames separate, and both results are emitted in order.
- Reset mid-frame: all state clears immediately and the block returns to DISARMED. No result is produced for the interrupted frame.

## Timing
- Reset values: `result_valid`=0, `peak_found`=0, every data output 0, best record 0, state DISARMED.
- Latency: if the last valid sample is captured at rising edge E, then `result_valid` is high for the cycle following edge E+4. The data outputs update at that same edge.
- Data outputs hold until the next `result_valid`. `result_valid` is never high on two consecutive cycles; the minimum spacing is 2 cycles (1-sample frame, 1-cycle gap).
- Window and threshold changes mid-frame have no effect until the next frame start.
- Throughput: 1 bin/clk, continuous.

## Test plan
- 1024-bin frame, `lo_bin`=2, `hi_bin`=1021, one tone at bin 100 (re=1000, im=-500), with bin 99 mag=40000 and bin 101 mag=90000 → single pulse 5 edges after the last sample: idx=100, re=1000, im=-500, mag=1250000, left=40000, right=90000, `peak_found`=1.
- Equal mags at bins 50 and 60, window 0..1023 → idx=50.
- Largest bin at 1 (outside `lo_bin`=2); winner at bin 2 → bin 1 ignored as a candidate, left=mag(bin 1). Winner at the last bin → right=0.
- Window 700..600 → pulse with `peak_found`=0 and all outputs 0. Winner mag 99 with `min_mag`=100 → `peak_found`=0 and the data is still reported.
- Two 8-bin frames separated by a 1-cycle gap, with different peaks → two pulses 9 cycles apart, each carrying its own frame's peak.
- Assert `rst` mid-frame, then release while `opd_o` is still high → no pulse for that frame; the next full frame produces a correct result. Extreme values re=im=-2^27 → mag=2^55 with no overflow.

Source files
------------

// File: rtl/fft_peak_search_if.sv
// Bin stream and peak-result bundle for fft_peak_search.
// The master side drives the FFT bin stream and receives the per-frame peak report.
interface fft_peak_search_if #(
  parameter int unsigned DW = 28,
  parameter int unsigned IW = 10,
  parameter int unsigned MW = 2 * DW
);
  // Bin stream and per-frame search configuration
  logic                 opd_o;
  logic [IW-1:0]        idx_o;
  logic signed [DW-1:0] fft_real;
  logic signed [DW-1:0] fft_imag;
  logic [IW-1:0]        lo_bin;
  logic [IW-1:0]        hi_bin;
  logic [MW-1:0]        min_mag;

  // Peak report, one pulse per frame
  logic                 result_valid;
  logic                 peak_found;
  logic [IW-1:0]        max_idx_result;
  logic signed [DW-1:0] max_re_result;
  logic signed [DW-1:0] max_im_result;
  logic [MW-1:0]        max_mag_result;
  logic [MW-1:0]        left_mag_result;
  logic [MW-1:0]        right_mag_result;

  modport master (
    output opd_o, idx_o, fft_real, fft_imag, lo_bin, hi_bin, min_mag,
    input  result_valid, peak_found, max_idx_result, max_re_result, max_im_result,
    input  max_mag_result, left_mag_result, right_mag_result
  );

  modport slave (
    input  opd_o, idx_o, fft_real, fft_imag, lo_bin, hi_bin, min_mag,
    output result_valid, peak_found, max_idx_result, max_re_result, max_im_result,
    output max_mag_result, left_mag_result, right_mag_result
  );
endinterface

// File: rtl/fft_peak_search.sv
// Streaming |X|^2 peak finder over a programmable bin window.
// Five-stage pipeline (capture, square, sum, compare, output), one bin per clock, no stalls.
// Frame boundaries travel with the samples as first/last tags so back-to-back frames stay apart.
module fft_peak_search #(
  parameter int unsigned DW = 28,
  parameter int unsigned IW = 10,
  localparam int unsigned MW = 2 * DW
) (
  input logic              clk,
  input logic              rst,
  fft_peak_search_if.slave bus
);

  typedef enum logic {StDisarmed, StArmed} state_e;
  state_e state_q, state_d;

  // S1: captured sample, tags and the frame's latched window/threshold
  logic                 s1_valid_q, s1_valid_d, s1_first_q, s1_first_d, s1_inwin_q, s1_inwin_d;
  logic [IW-1:0]        s1_idx_q, s1_idx_d, win_lo_q, win_lo_d, win_hi_q, win_hi_d;
  logic signed [DW-1:0] s1_re_q, s1_re_d, s1_im_q, s1_im_d;
  logic [MW-1:0]        s1_thr_q, s1_thr_d;
  // S2: squares
  logic                 s2_valid_q, s2_valid_d, s2_first_q, s2_first_d, s2_last_q, s2_last_d;
  logic                 s2_inwin_q, s2_inwin_d;
  logic [IW-1:0]        s2_idx_q, s2_idx_d;
  logic signed [DW-1:0] s2_re_q, s2_re_d, s2_im_q, s2_im_d;
  logic [MW-2:0]        s2_re_sq_q, s2_re_sq_d, s2_im_sq_q, s2_im_sq_d;
  logic [MW-1:0]        s2_thr_q, s2_thr_d;
  // S3: magnitude
  logic                 s3_valid_q, s3_valid_d, s3_first_q, s3_first_d, s3_last_q, s3_last_d;
  logic                 s3_inwin_q, s3_inwin_d;
  logic [IW-1:0]        s3_idx_q, s3_idx_d;
  logic signed [DW-1:0] s3_re_q, s3_re_d, s3_im_q, s3_im_d;
  logic [MW-1:0]        s3_mag_q, s3_mag_d, s3_thr_q, s3_thr_d;
  // S4: best record plus neighbour shadows
  logic                 seen_q, seen_d, pend_q, pend_d, s4_last_q, s4_last_d;
  logic [IW-1:0]        best_idx_q, best_idx_d;
  logic signed [DW-1:0] best_re_q, best_re_d, best_im_q, best_im_d;
  logic [MW-1:0]        best_mag_q, best_mag_d, left_q, left_d, right_q, right_d;
  logic [MW-1:0]        prev_mag_q, prev_mag_d, s4_thr_q, s4_thr_d;
  // S5: registered outputs
  logic                 res_valid_q, res_valid_d, found_q, found_d;
  logic [IW-1:0]        out_idx_q, out_idx_d;
  logic signed [DW-1:0] out_re_q, out_re_d, out_im_q, out_im_d;
  logic [MW-1:0]        out_mag_q, out_mag_d, out_left_q, out_left_d, out_right_q, out_right_d;

  logic                 accept, first;
  logic [IW-1:0]        lo_cur, hi_cur;
  logic signed [MW-1:0] re_ext, im_ext, re_sq_full, im_sq_full;
  logic                 seen_base, pend_base, upd;
  logic [MW-1:0]        mag_base, prev_base;

  // Arming: a frame already in flight when reset releases is skipped until opd_o drops
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StDisarmed: if (!bus.opd_o) state_d = StArmed;
      StArmed:    state_d = StArmed;
      default:    state_d = StDisarmed;
    endcase
  end

  // S1..S3 next state: capture/tag, square, sum
  always_comb begin
    accept     = bus.opd_o && (state_q == StArmed);
    first      = accept && !s1_valid_q;
    lo_cur     = first ? bus.lo_bin : win_lo_q;
    hi_cur     = first ? bus.hi_bin : win_hi_q;
    win_lo_d   = lo_cur;
    win_hi_d   = hi_cur;
    s1_valid_d = accept;
    s1_first_d = first;
    s1_inwin_d = accept && (bus.idx_o >= lo_cur) && (bus.idx_o <= hi_cur);
    s1_idx_d   = bus.idx_o;
    s1_re_d    = bus.fft_real;
    s1_im_d    = bus.fft_imag;
    s1_thr_d   = first ? bus.min_mag : s1_thr_q;

    re_ext     = {{(MW - DW){s1_re_q[DW-1]}}, s1_re_q};
    im_ext     = {{(MW - DW){s1_im_q[DW-1]}}, s1_im_q};
    re_sq_full = re_ext * re_ext;
    im_sq_full = im_ext * im_ext;
    s2_valid_d = s1_valid_q;
    s2_first_d = s1_first_q;
    // The last sample is the one whose successor cycle has opd_o low
    s2_last_d  = s1_valid_q && !bus.opd_o;
    s2_inwin_d = s1_inwin_q;
    s2_idx_d   = s1_idx_q;
    s2_re_d    = s1_re_q;
    s2_im_d    = s1_im_q;
    // A square is non-negative and at most 2^(2DW-2), so the top bit is always zero
    s2_re_sq_d = re_sq_full[MW-2:0];
    s2_im_sq_d = im_sq_full[MW-2:0];
    s2_thr_d   = s1_thr_q;

    s3_valid_d = s2_valid_q;
    s3_first_d = s2_first_q;
    s3_last_d  = s2_last_q;
    s3_inwin_d = s2_inwin_q;
    s3_idx_d   = s2_idx_q;
    s3_re_d    = s2_re_q;
    s3_im_d    = s2_im_q;
    s3_mag_d   = {1'b0, s2_re_sq_q} + {1'b0, s2_im_sq_q};
    s3_thr_d   = s2_thr_q;
  end

  // S4: compare/update; strict '>' keeps the lowest-index bin on ties
  always_comb begin
    seen_d     = seen_q;
    pend_d     = pend_q;
    best_idx_d = best_idx_q;
    best_re_d  = best_re_q;
    best_im_d  = best_im_q;
    best_mag_d = best_mag_q;
    left_d     = left_q;
    right_d    = right_q;
    prev_mag_d = prev_mag_q;
    seen_base  = s3_first_q ? 1'b0 : seen_q;
    pend_base  = s3_first_q ? 1'b0 : pend_q;
    mag_base   = s3_first_q ? '0 : best_mag_q;
    prev_base  = s3_first_q ? '0 : prev_mag_q;
    upd        = s3_valid_q && s3_inwin_q && (!seen_base || (s3_mag_q > mag_base));
    s4_last_d  = s3_valid_q && s3_last_q;
    s4_thr_d   = (s3_valid_q && s3_last_q) ? s3_thr_q : s4_thr_q;
    if (s3_valid_q) begin
      if (s3_first_q) begin
        seen_d     = 1'b0;
        pend_d     = 1'b0;
        best_idx_d = '0;
        best_re_d  = '0;
        best_im_d  = '0;
        best_mag_d = '0;
        left_d     = '0;
        right_d    = '0;
      end
      if (upd) begin
        seen_d     = 1'b1;
        pend_d     = 1'b1;
        best_idx_d = s3_idx_q;
        best_re_d  = s3_re_q;
        best_im_d  = s3_im_q;
        best_mag_d = s3_mag_q;
        left_d     = prev_base;
        right_d    = '0;
      end else if (pend_base) begin
        right_d = s3_mag_q;
        pend_d  = 1'b0;
      end
      prev_mag_d = s3_mag_q;
    end
  end

  // S5: publish the frame's record when its last tag arrives; otherwise hold
  always_comb begin
    res_valid_d = s4_last_q;
    found_d     = found_q;
    out_idx_d   = out_idx_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    out_mag_d   = out_mag_q;
    out_left_d  = out_left_q;
    out_right_d = out_right_q;
    if (s4_last_q) begin
      found_d     = seen_q && (best_mag_q >= s4_thr_q);
      out_idx_d   = seen_q ? best_idx_q : '0;
      out_re_d    = seen_q ? best_re_q : '0;
      out_im_d    = seen_q ? best_im_q : '0;
      out_mag_d   = seen_q ? best_mag_q : '0;
      out_left_d  = seen_q ? left_q : '0;
      out_right_d = seen_q ? right_q : '0;
    end
  end

  // State registers; reset clears the whole pipeline and disarms
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StDisarmed;
      s1_valid_q <= 1'b0; s1_first_q <= 1'b0; s1_inwin_q <= 1'b0; s1_idx_q <= '0;
      s1_re_q    <= '0;   s1_im_q    <= '0;   s1_thr_q   <= '0;   win_lo_q <= '0;
      win_hi_q   <= '0;
      s2_valid_q <= 1'b0; s2_first_q <= 1'b0; s2_last_q  <= 1'b0; s2_inwin_q <= 1'b0;
      s2_idx_q   <= '0;   s2_re_q    <= '0;   s2_im_q    <= '0;   s2_re_sq_q <= '0;
      s2_im_sq_q <= '0;   s2_thr_q   <= '0;
      s3_valid_q <= 1'b0; s3_first_q <= 1'b0; s3_last_q  <= 1'b0; s3_inwin_q <= 1'b0;
      s3_idx_q   <= '0;   s3_re_q    <= '0;   s3_im_q    <= '0;   s3_mag_q   <= '0;
      s3_thr_q   <= '0;
      seen_q     <= 1'b0; pend_q     <= 1'b0; s4_last_q  <= 1'b0; best_idx_q <= '0;
      best_re_q  <= '0;   best_im_q  <= '0;   best_mag_q <= '0;   left_q     <= '0;
      right_q    <= '0;   prev_mag_q <= '0;   s4_thr_q   <= '0;
      res_valid_q <= 1'b0; found_q   <= 1'b0; out_idx_q  <= '0;   out_re_q   <= '0;
      out_im_q   <= '0;   out_mag_q  <= '0;   out_left_q <= '0;   out_right_q <= '0;
    end else begin
      state_q    <= state_d;
      s1_valid_q <= s1_valid_d; s1_first_q <= s1_first_d; s1_inwin_q <= s1_inwin_d;
      s1_idx_q   <= s1_idx_d;   s1_re_q    <= s1_re_d;    s1_im_q    <= s1_im_d;
      s1_thr_q   <= s1_thr_d;   win_lo_q   <= win_lo_d;   win_hi_q   <= win_hi_d;
      s2_valid_q <= s2_valid_d; s2_first_q <= s2_first_d; s2_last_q  <= s2_last_d;
      s2_inwin_q <= s2_inwin_d; s2_idx_q   <= s2_idx_d;   s2_re_q    <= s2_re_d;
      s2_im_q    <= s2_im_d;    s2_re_sq_q <= s2_re_sq_d; s2_im_sq_q <= s2_im_sq_d;
      s2_thr_q   <= s2_thr_d;
      s3_valid_q <= s3_valid_d; s3_first_q <= s3_first_d; s3_last_q  <= s3_last_d;
      s3_inwin_q <= s3_inwin_d; s3_idx_q   <= s3_idx_d;   s3_re_q    <= s3_re_d;
      s3_im_q    <= s3_im_d;    s3_mag_q   <= s3_mag_d;   s3_thr_q   <= s3_thr_d;
      seen_q     <= seen_d;     pend_q     <= pend_d;     s4_last_q  <= s4_last_d;
      best_idx_q <= best_idx_d; best_re_q  <= best_re_d;  best_im_q  <= best_im_d;
      best_mag_q <= best_mag_d; left_q     <= left_d;     right_q    <= right_d;
      prev_mag_q <= prev_mag_d; s4_thr_q   <= s4_thr_d;
      res_valid_q <= res_valid_d; found_q  <= found_d;    out_idx_q  <= out_idx_d;
      out_re_q   <= out_re_d;   out_im_q   <= out_im_d;   out_mag_q  <= out_mag_d;
      out_left_q <= out_left_d; out_right_q <= out_right_d;
    end
  end

  assign bus.result_valid     = res_valid_q;
  assign bus.peak_found       = found_q;
  assign bus.max_idx_result   = out_idx_q;
  assign bus.max_re_result    = out_re_q;
  assign bus.max_im_result    = out_im_q;
  assign bus.max_mag_result   = out_mag_q;
  assign bus.left_mag_result  = out_left_q;
  assign bus.right_mag_result = out_right_q;

endmodule

// File: tb/tb_fft_peak_search.sv
// Bench for fft_peak_search: table of frames with hand-derived peak reports, a scoreboard
// queue filled as each frame is driven, and a monitor that pops on every result pulse.
module tb_fft_peak_search;

  localparam int NV = 12;

  typedef struct packed {
    int     n;
    int     lo;
    int     hi;
    int     gap;
    longint thr;
    int     p0i; longint p0re; longint p0im;
    int     p1i; longint p1re; longint p1im;
    int     p2i; longint p2re; longint p2im;
    int     e_idx; longint e_re; longint e_im; longint e_mag; longint e_l; longint e_r;
    bit     e_f;
  } vec_t;

  typedef struct packed {
    logic [9:0]  idx;
    logic [27:0] re;
    logic [27:0] im;
    logic [55:0] mag;
    logic [55:0] l;
    logic [55:0] r;
    logic        f;
    logic [31:0] cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  vec_t        vecs[NV];
  exp_t        sb_q[$];
  exp_t        held;
  bit          hold_chk = 0;

  fft_peak_search_if #(.DW(28), .IW(10)) bus ();

  fft_peak_search #(.DW(28), .IW(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Background spectrum: small values, mag <= 13 everywhere
  function automatic longint bg_re(input int i);
    return longint'(i % 7) - 3;
  endfunction
  function automatic longint bg_im(input int i);
    return longint'(i % 5) - 2;
  endfunction
  function automatic longint bg_mag(input int i);
    return bg_re(i) * bg_re(i) + bg_im(i) * bg_im(i);
  endfunction

  function automatic longint s_re(input vec_t v, input int i);
    if (i == v.p0i) return v.p0re;
    if (i == v.p1i) return v.p1re;
    if (i == v.p2i) return v.p2re;
    return bg_re(i);
  endfunction
  function automatic longint s_im(input vec_t v, input int i);
    if (i == v.p0i) return v.p0im;
    if (i == v.p1i) return v.p1im;
    if (i == v.p2i) return v.p2im;
    return bg_im(i);
  endfunction

  function automatic vec_t mk(input int n, input int lo, input int hi, input longint thr,
                              input int gap,
                              input int p0i, input longint p0re, input longint p0im,
                              input int p1i, input longint p1re, input longint p1im,
                              input int p2i, input longint p2re, input longint p2im,
                              input int ei, input longint ere, input longint eim,
                              input longint emag, input longint el, input longint er,
                              input bit ef);
    vec_t v;
    v.n = n; v.lo = lo; v.hi = hi; v.thr = thr; v.gap = gap;
    v.p0i = p0i; v.p0re = p0re; v.p0im = p0im;
    v.p1i = p1i; v.p1re = p1re; v.p1im = p1im;
    v.p2i = p2i; v.p2re = p2re; v.p2im = p2im;
    v.e_idx = ei; v.e_re = ere; v.e_im = eim; v.e_mag = emag; v.e_l = el; v.e_r = er;
    v.e_f = ef;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic drive_sample(input vec_t v, input int i);
    bus.opd_o    = 1'b1;
    bus.idx_o    = 10'(i);
    bus.fft_real = 28'(s_re(v, i));
    bus.fft_imag = 28'(s_im(v, i));
    if (i == 0) begin
      bus.lo_bin  = 10'(v.lo);
      bus.hi_bin  = 10'(v.hi);
      bus.min_mag = 56'(v.thr);
    end else begin
      // Hostile config mid-frame; must be ignored until the next frame start
      bus.lo_bin  = 10'd1023;
      bus.hi_bin  = 10'd0;
      bus.min_mag = '1;
    end
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    for (int i = 0; i < v.n; i++) begin
      @(negedge clk);
      drive_sample(v, i);
    end
    e.idx = 10'(v.e_idx);
    e.re  = 28'(v.e_re);
    e.im  = 28'(v.e_im);
    e.mag = 56'(v.e_mag);
    e.l   = 56'(v.e_l);
    e.r   = 56'(v.e_r);
    e.f   = v.e_f;
    e.cyc = cyc + 5;
    sb_q.push_back(e);
    repeat (v.gap) begin
      @(negedge clk);
      bus.opd_o = 1'b0;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && sb_q.size() > 0; k++) @(negedge clk);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    rst          = 1'b0;
    bus.opd_o    = 1'b0;
    bus.idx_o    = '0;
    bus.fft_real = '0;
    bus.fft_imag = '0;
    bus.lo_bin   = '0;
    bus.hi_bin   = '0;
    bus.min_mag  = '0;

    //          n    lo   hi    thr gap  peak0             peak1            peak2
    //          expected: idx re im mag left right found
    vecs[0]  = mk(1024, 2, 1021, 0, 3, 99, 200, 0, 100, 1000, -500, 101, 0, 300,
                  100, 1000, -500, 1250000, 40000, 90000, 1);
    vecs[1]  = mk(128, 0, 1023, 0, 2, 50, 300, 400, 60, 400, 300, -1, 0, 0,
                  50, 300, 400, 250000, bg_mag(49), bg_mag(51), 1);
    vecs[2]  = mk(16, 2, 15, 0, 2, 1, 5000, 0, 2, 100, 100, -1, 0, 0,
                  2, 100, 100, 20000, 25000000, bg_mag(3), 1);
    vecs[3]  = mk(16, 0, 15, 0, 2, 15, -700, 0, -1, 0, 0, -1, 0, 0,
                  15, -700, 0, 490000, bg_mag(14), 0, 1);
    vecs[4]  = mk(1024, 700, 600, 0, 2, 650, 9000, 9000, -1, 0, 0, -1, 0, 0,
                  0, 0, 0, 0, 0, 0, 0);
    vecs[5]  = mk(8, 0, 7, 100, 2, 4, 7, -7, -1, 0, 0, -1, 0, 0,
                  4, 7, -7, 98, bg_mag(3), bg_mag(5), 0);
    vecs[6]  = mk(8, 0, 7, 98, 2, 4, 7, -7, -1, 0, 0, -1, 0, 0,
                  4, 7, -7, 98, bg_mag(3), bg_mag(5), 1);
    vecs[7]  = mk(8, 0, 7, 0, 2, 3, -134217728, -134217728, -1, 0, 0, -1, 0, 0,
                  3, -134217728, -134217728, 64'sd36028797018963968, bg_mag(2), bg_mag(4), 1);
    vecs[8]  = mk(1, 0, 0, 600, 1, 0, 10, 20, -1, 0, 0, -1, 0, 0,
                  0, 10, 20, 500, 0, 0, 0);
    vecs[9]  = mk(1, 0, 0, 0, 1, 0, -3, 4, -1, 0, 0, -1, 0, 0,
                  0, -3, 4, 25, 0, 0, 1);
    vecs[10] = mk(8, 0, 7, 0, 1, 5, 50, 0, -1, 0, 0, -1, 0, 0,
                  5, 50, 0, 2500, bg_mag(4), bg_mag(6), 1);
    vecs[11] = mk(8, 0, 7, 0, 3, 2, 0, -60, -1, 0, 0, -1, 0, 0,
                  2, 0, -60, 3600, bg_mag(1), bg_mag(3), 1);

    // Result monitor: pops the scoreboard on each pulse, then checks width and hold
    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (hold_chk) begin
          hold_chk = 0;
          chk("pulse_width", 64'(bus.result_valid), 64'(0));
          if (!bus.result_valid) begin
            chk("hold_idx", 64'(bus.max_idx_result), 64'(held.idx));
            chk("hold_mag", 64'(bus.max_mag_result), 64'(held.mag));
          end
        end
        if (rst && bus.result_valid) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_pulse", 64'(bus.result_valid), 64'(0));
          end else begin
            e = sb_q.pop_front();
            chk("latency",    64'(cyc), 64'(e.cyc));
            chk("peak_found", 64'(bus.peak_found), 64'(e.f));
            chk("idx",        64'(bus.max_idx_result), 64'(e.idx));
            chk("re",         64'($unsigned(bus.max_re_result)), 64'(e.re));
            chk("im",         64'($unsigned(bus.max_im_result)), 64'(e.im));
            chk("mag",        64'(bus.max_mag_result), 64'(e.mag));
            chk("left_mag",   64'(bus.left_mag_result), 64'(e.l));
            chk("right_mag",  64'(bus.right_mag_result), 64'(e.r));
            held     = e;
            hold_chk = 1;
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    chk("rst_result_valid", 64'(bus.result_valid), 64'(0));
    chk("rst_peak_found",   64'(bus.peak_found), 64'(0));
    chk("rst_idx",          64'(bus.max_idx_result), 64'(0));
    chk("rst_mag",          64'(bus.max_mag_result), 64'(0));
    chk("rst_left",         64'(bus.left_mag_result), 64'(0));
    chk("rst_right",        64'(bus.right_mag_result), 64'(0));
    rst = 1'b1;

    for (int k = 0; k < NV; k++) run_vec(vecs[k]);
    drain();

    // Reset mid-frame, released while opd_o is still high: that frame must not report
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 20) begin
        rst = 1'b0;
        #1;
        chk("midrst_result_valid", 64'(bus.result_valid), 64'(0));
        chk("midrst_peak_found",   64'(bus.peak_found), 64'(0));
        chk("midrst_mag",          64'(bus.max_mag_result), 64'(0));
        chk("midrst_idx",          64'(bus.max_idx_result), 64'(0));
      end
      if (i == 25) rst = 1'b1;
      drive_sample(vecs[1], i);
    end
    @(negedge clk);
    bus.opd_o = 1'b0;
    repeat (12) @(negedge clk);

    run_vec(vecs[7]);
    drain();
    chk("pending_results", 64'(sb_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
